ram2p_fifo_ctrl: RTL and testbench
==================================

# ram2p_fifo_ctrl

Single-clock FIFO controller that sits directly upstream of a `ram2p` instance: it owns the write/read pointers and drives RAM port A for writes and port B for reads. It presents valid/ready streams on both sides and hides the RAM's one-cycle registered read latency behind a two-entry output buffer. Full throughput is one word per clock in and out. Used wherever a block needs a deep FIFO built on the team's dual-port RAM.

## Interface
Parameters:
- `AWID`, 8, RAM address width.
- `DEPTH`, 256, RAM words; 2 ≤ DEPTH ≤ 2**AWID; need not be a power of two.
- `DWID`, 16, data width.

Ports:
- `clk` in 1: single clock; the RAM's `clka` and `clkb` both tie to it.
- `rst` in 1: synchronous, active-high reset.
- `i_wr_valid` in 1: write request.
- `o_wr_ready` out 1: write accepted when valid && ready.
- `i_wr_data` in DWID: write data.
- `o_rd_valid` out 1: read data available.
- `i_rd_ready` in 1: consumer takes the word when valid && ready.
- `o_rd_data` out DWID: head-of-FIFO word.
- `o_count` out AWID+2: total occupancy, 0..DEPTH+2.
- `o_empty` out 1: o_count == 0.
- `o_ram_wea` out 1: drives RAM `i_wea`.
- `o_ram_addra` out AWID: drives RAM `i_addra`.
- `o_ram_data` out DWID: drives RAM `i_data`.
- `o_ram_web` out 1: constant 0.
- `o_ram_addrb` out AWID: drives RAM `i_addrb`.
- `i_ram_datb` in DWID: from RAM `o_datb`.

## Operation
- State: `wptr` and `rptr` (0..DEPTH-1), `mem_cnt` (0..DEPTH), `fetch_d` (1 bit: read in flight), and an output buffer of 2 entries (head + skid) with `buf_cnt` (0..2).
- Write: `o_wr_ready = !rst && mem_cnt < DEPTH`.
  - `o_ram_wea = i_wr_valid && o_wr_ready`; `o_ram_addra = wptr`; `o_ram_data = i_wr_data`. These are combinational.
  - On each accepted write, wptr advances.
- Fetch: `fetch = mem_cnt > 0 && (buf_cnt + fetch_d - pop) < 2`, where `pop = o_rd_valid && i_rd_ready`.
  - `o_ram_addrb = rptr` always. On fetch, rptr advances and fetch_d is 1 next cycle.
  - When fetch_d = 1, `i_ram_datb` is pushed into the output buffer.
- mem_cnt is the registered count and excludes the same-cycle write. The controller therefore never fetches the address being written that cycle, so the RAM's old-data read-during-write behaviour is never exposed.
- `mem_cnt` next = mem_cnt + write − fetch. Simultaneous write and fetch leaves it unchanged.
- Output buffer: `o_rd_valid = buf_cnt > 0`; `o_rd_data` = head entry.
  - On pop, the skid entry moves to head.
  - A push with a pop goes to the first free slot after the shift.
- `o_count = mem_cnt + fetch_d + buf_cnt`.
- Pointer wrap: explicit compare to DEPTH-1, then reset to 0. No modulo-2**AWID wrap is relied on.
- Full: mem_cnt == DEPTH blocks writes. The buffer may still hold 2 words, so o_count reaches DEPTH+2.
- Empty: no fetch is issued and o_rd_valid = 0. A pop without o_rd_valid is ignored.

## Timing
- Reset (synchronous, on `rst` high at a clk edge): wptr, rptr, mem_cnt, fetch_d, buf_cnt = 0; o_rd_data = 0; o_rd_valid = 0; o_empty = 1; o_count = 0.
  - During rst, o_wr_ready = 0, o_ram_wea = 0, o_ram_addra = 0, o_ram_addrb = 0.
- Reset mid-operation discards all contents. RAM contents are stale but unreachable. A fetch already in flight is dropped.
- Write→read latency into an empty FIFO:
  - write accepted in cycle t;
  - fetch in cycle t+1;
  - RAM data in cycle t+2, pushed at the end of t+2;
  - o_rd_valid in t+3.
- Steady state with i_rd_ready held 1: one word per clock, no bubbles.
- Backpressure: i_rd_ready = 0 holds o_rd_data stable. At most 2 words are buffered, then fetch stops.
- All registered outputs change only on the clk rising edge. o_wr_ready and the RAM port-A signals are combinational from registers and inputs.

## Structure
- No shared package needed; the widths derive from parameters.
- Localparams inside the module: `CW = AWID+2` and `LAST = DEPTH-1`.
- Natural sub-module: `fifo_out_skid`, the 2-entry output buffer with push/pop, buf_cnt, and o_rd_valid/o_rd_data.
- The `ram2p` instance lives in the parent, not in this block.

## Test plan
- Reset then idle → o_empty = 1, o_count = 0, o_rd_valid = 0, o_wr_ready = 1, o_ram_wea = 0.
- Write 0x1234 once with i_rd_ready = 1 → o_rd_valid rises exactly 3 cycles after the write handshake with o_rd_data = 0x1234; o_count goes 1,1,1,0.
- DEPTH = 5, stream 0..9 in with i_rd_ready = 0 → o_wr_ready drops after 7 writes, o_count = 7; then drain → data 0..6 in order; the pointers wrap.
- Continuous write and read at 1/clk for 600 words → output sequence is identical to the input, no bubbles after the first valid, o_count stable at 3.
- Random i_wr_valid/i_rd_ready (50%) for 10k cycles against a scoreboard model → no loss, duplication or reorder; o_count matches the model every cycle.
- Assert rst while 4 words are held and a fetch is in flight → next cycle o_count = 0, o_rd_valid = 0; the next write of 0xBEEF reads back as 0xBEEF.

Source files
------------

// File: rtl/ram2p_fifo_ctrl_pkg.sv
// ram2p_fifo_ctrl_pkg: shared helpers for the ram2p FIFO controller.
package ram2p_fifo_ctrl_pkg;

    // Pointer advance with an explicit wrap at the last valid RAM address.
    function automatic int wrap_inc(input int p, input int last);
        return (p == last) ? 0 : p + 1;
    endfunction

endpackage

// File: rtl/fifo_out_skid.sv
// fifo_out_skid: two-entry head/skid output buffer absorbing the RAM read latency.
module fifo_out_skid
    import ram2p_fifo_ctrl_pkg::*;
#(
    parameter int DWID = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push_i,
    input  logic [DWID-1:0] data_i,
    input  logic            pop_i,
    output logic            valid_o,
    output logic [DWID-1:0] data_o,
    output logic [1:0]      cnt_o
);
    logic [DWID-1:0] head_q, head_d, skid_q, skid_d;
    logic [1:0]      cnt_q, cnt_d, left;

    // Occupancy after the pop decides which slot a same-cycle push lands in.
    assign left   = cnt_q - {1'b0, pop_i};
    assign cnt_d  = left + {1'b0, push_i};
    assign head_d = (push_i && left == 2'd0) ? data_i : (pop_i ? skid_q : head_q);
    assign skid_d = (push_i && left == 2'd1) ? data_i : skid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            skid_q <= '0;
            cnt_q  <= '0;
        end else begin
            head_q <= head_d;
            skid_q <= skid_d;
            cnt_q  <= cnt_d;
        end
    end

    assign valid_o = cnt_q != 2'd0;
    assign data_o  = head_q;
    assign cnt_o   = cnt_q;
endmodule

// File: rtl/ram2p_fifo_ctrl.sv
// ram2p_fifo_ctrl: FIFO controller driving a dual-port RAM, port A writes, port B reads.
module ram2p_fifo_ctrl
    import ram2p_fifo_ctrl_pkg::*;
#(
    parameter int AWID  = 8,
    parameter int DEPTH = 256,
    parameter int DWID  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_valid,
    output logic              o_wr_ready,
    input  logic [DWID-1:0]   i_wr_data,
    output logic              o_rd_valid,
    input  logic              i_rd_ready,
    output logic [DWID-1:0]   o_rd_data,
    output logic [AWID+1:0]   o_count,
    output logic              o_empty,
    output logic              o_ram_wea,
    output logic [AWID-1:0]   o_ram_addra,
    output logic [DWID-1:0]   o_ram_data,
    output logic              o_ram_web,
    output logic [AWID-1:0]   o_ram_addrb,
    input  logic [DWID-1:0]   i_ram_datb
);
    localparam int CW = AWID + 2;
    localparam int LAST = DEPTH - 1;
    localparam logic [AWID:0] DEPTH_C = (AWID + 1)'(DEPTH);

    logic [AWID-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AWID:0]   mem_cnt_q, mem_cnt_d;
    logic            fetch_q, wr, fetch, pop;
    logic [1:0]      buf_cnt;

    assign o_wr_ready = !rst && mem_cnt_q < DEPTH_C;
    assign wr         = i_wr_valid && o_wr_ready;
    assign pop        = o_rd_valid && i_rd_ready;
    // Keep buffer + in-flight read within the two slots after this cycle's pop.
    assign fetch      = (mem_cnt_q != '0) &&
                        ({1'b0, buf_cnt} + {2'b0, fetch_q} < 3'd2 + {2'b0, pop});

    assign wptr_d    = wr ? AWID'(wrap_inc(int'(wptr_q), LAST)) : wptr_q;
    assign rptr_d    = fetch ? AWID'(wrap_inc(int'(rptr_q), LAST)) : rptr_q;
    assign mem_cnt_d = mem_cnt_q + {{AWID{1'b0}}, wr} - {{AWID{1'b0}}, fetch};

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            mem_cnt_q <= '0;
            fetch_q   <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            mem_cnt_q <= mem_cnt_d;
            fetch_q   <= fetch;
        end
    end

    fifo_out_skid #(.DWID(DWID)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fetch_q),
        .data_i  (i_ram_datb),
        .pop_i   (pop),
        .valid_o (o_rd_valid),
        .data_o  (o_rd_data),
        .cnt_o   (buf_cnt)
    );

    assign o_ram_wea   = wr;
    assign o_ram_addra = rst ? '0 : wptr_q;
    assign o_ram_data  = i_wr_data;
    assign o_ram_web   = 1'b0;
    assign o_ram_addrb = rst ? '0 : rptr_q;
    assign o_count     = CW'(mem_cnt_q) + CW'(fetch_q) + CW'(buf_cnt);
    assign o_empty     = o_count == '0;
endmodule

// File: tb/tb_ram2p_fifo_ctrl.sv
// tb_ram2p_fifo_ctrl: directed + random stimulus with a queue scoreboard and RAM model.
module tb_ram2p_fifo_ctrl;
    localparam int AWID = 3;
    localparam int DEPTH = 5;
    localparam int DWID = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_wr_valid, o_wr_ready, o_rd_valid, i_rd_ready;
    logic [DWID-1:0]   i_wr_data, o_rd_data, o_ram_data, i_ram_datb;
    logic [AWID+1:0]   o_count;
    logic              o_empty, o_ram_wea, o_ram_web;
    logic [AWID-1:0]   o_ram_addra, o_ram_addrb;

    always #5 clk = ~clk;

    ram2p_fifo_ctrl #(.AWID(AWID), .DEPTH(DEPTH), .DWID(DWID)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_wr_valid  (i_wr_valid),
        .o_wr_ready  (o_wr_ready),
        .i_wr_data   (i_wr_data),
        .o_rd_valid  (o_rd_valid),
        .i_rd_ready  (i_rd_ready),
        .o_rd_data   (o_rd_data),
        .o_count     (o_count),
        .o_empty     (o_empty),
        .o_ram_wea   (o_ram_wea),
        .o_ram_addra (o_ram_addra),
        .o_ram_data  (o_ram_data),
        .o_ram_web   (o_ram_web),
        .o_ram_addrb (o_ram_addrb),
        .i_ram_datb  (i_ram_datb)
    );

    // Dual-port RAM model: registered read returning old data on collision.
    logic [DWID-1:0] ram [0:(1<<AWID)-1];
    always_ff @(posedge clk) begin
        if (o_ram_wea) ram[o_ram_addra] <= o_ram_data;
        i_ram_datb <= ram[o_ram_addrb];
    end

    int n_tests = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: accepted writes queue up, every read handshake pops and compares.
    logic [DWID-1:0] exp_q[$];
    int  cnt_m = 0;
    bit  mon_en = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            chk("count_model", int'(o_count), cnt_m);
            if (o_ram_web) chk("ram_web", 1, 0);
            if (rst) begin
                exp_q.delete();
                cnt_m = 0;
            end else begin
                if (i_wr_valid && o_wr_ready) begin
                    exp_q.push_back(i_wr_data);
                    cnt_m++;
                end
                if (o_rd_valid && i_rd_ready) begin
                    if (exp_q.size() == 0) chk("rd_unexpected", 1, 0);
                    else chk("rd_data", int'(o_rd_data), int'(exp_q.pop_front()));
                    cnt_m--;
                end
            end
        end
    end

    initial begin
        int nxt, got, seen, bubbles, badcnt;
        i_wr_valid = 1'b0;
        i_rd_ready = 1'b0;
        i_wr_data  = '0;
        tick();
        tick();
        @(negedge clk);
        chk("rst_wr_ready", int'(o_wr_ready), 0);
        chk("rst_wea", int'(o_ram_wea), 0);
        chk("rst_addra", int'(o_ram_addra), 0);
        chk("rst_addrb", int'(o_ram_addrb), 0);
        tick();
        rst = 1'b0;
        mon_en = 1;
        @(negedge clk);
        chk("idle_empty", int'(o_empty), 1);
        chk("idle_count", int'(o_count), 0);
        chk("idle_rd_valid", int'(o_rd_valid), 0);
        chk("idle_wr_ready", int'(o_wr_ready), 1);
        chk("idle_wea", int'(o_ram_wea), 0);

        // Single word latency
        tick();
        i_rd_ready = 1'b1;
        i_wr_valid = 1'b1;
        i_wr_data  = 16'h1234;
        @(negedge clk);
        chk("lat_wea", int'(o_ram_wea), 1);
        tick();
        i_wr_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("lat_valid", int'(o_rd_valid), (k == 3) ? 1 : 0);
            chk("lat_count", int'(o_count), 1);
            if (k < 3) tick();
        end
        chk("lat_data", int'(o_rd_data), 16'h1234);
        tick();
        @(negedge clk);
        chk("lat_count_after", int'(o_count), 0);

        // Fill to full with the consumer stalled, then drain
        tick();
        i_rd_ready = 1'b0;
        nxt = 0;
        for (int c = 0; c < 15; c++) begin
            i_wr_valid = nxt < 10;
            i_wr_data  = 16'(nxt);
            @(negedge clk);
            if (i_wr_valid && o_wr_ready) nxt++;
            tick();
        end
        i_wr_valid = 1'b0;
        @(negedge clk);
        chk("full_accepted", nxt, 7);
        chk("full_count", int'(o_count), 7);
        chk("full_wr_ready", int'(o_wr_ready), 0);
        tick();
        i_rd_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (o_rd_valid) begin
                chk("drain_order", int'(o_rd_data), got);
                got++;
            end
            tick();
        end
        chk("drain_total", got, 7);

        // Continuous streaming
        nxt = 0;
        seen = 0;
        bubbles = 0;
        badcnt = 0;
        for (int c = 0; c < 700 && nxt < 600; c++) begin
            i_wr_valid = 1'b1;
            i_wr_data  = 16'(1000 + nxt);
            @(negedge clk);
            if (o_rd_valid) seen = 1;
            else if (seen != 0) bubbles++;
            if (seen != 0 && o_count != 5'd3) badcnt++;
            if (o_wr_ready) nxt++;
            tick();
        end
        i_wr_valid = 1'b0;
        chk("stream_words", nxt, 600);
        chk("stream_bubbles", bubbles, 0);
        chk("stream_count_not3", badcnt, 0);
        repeat (10) tick();
        @(negedge clk);
        chk("stream_empty", int'(o_empty), 1);

        // Random traffic against the scoreboard
        for (int c = 0; c < 10000; c++) begin
            i_wr_valid = 1'($urandom_range(0, 1));
            i_rd_ready = 1'($urandom_range(0, 1));
            i_wr_data  = 16'($urandom);
            tick();
        end
        i_wr_valid = 1'b0;
        i_rd_ready = 1'b1;
        repeat (15) tick();
        @(negedge clk);
        chk("rand_empty", int'(o_empty), 1);

        // Reset with words held and a fetch in flight
        i_rd_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            i_wr_valid = 1'b1;
            i_wr_data  = 16'(16'h0A00 + k);
            tick();
        end
        i_wr_valid = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("held_count", int'(o_count), 4);
        tick();
        i_wr_valid = 1'b1;
        i_wr_data  = 16'h0A04;
        i_rd_ready = 1'b1;
        tick();
        i_wr_valid = 1'b0;
        i_rd_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("pre_rst_count", int'(o_count), 4);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_count", int'(o_count), 0);
        chk("post_rst_valid", int'(o_rd_valid), 0);
        chk("post_rst_empty", int'(o_empty), 1);
        tick();
        i_wr_valid = 1'b1;
        i_wr_data  = 16'hBEEF;
        i_rd_ready = 1'b1;
        tick();
        i_wr_valid = 1'b0;
        got = 0;
        for (int c = 0; c < 10 && got == 0; c++) begin
            @(negedge clk);
            if (o_rd_valid) begin
                chk("beef_data", int'(o_rd_data), 16'hBEEF);
                got = 1;
            end
            tick();
        end
        chk("beef_seen", got, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
